// File: rtl/ws_frame_scheduler.sv
// Frame scheduler for a WS281x-style LED strip: arbitrates two pixel sources, fetches/sends
// NUM_LEDS pixels, then holds the latch gap. Define WS_SCHED_PENDING_EN to queue one busy frame_start.
module ws_frame_scheduler #(
   parameter int NUM_LEDS     = 50,
   parameter int LATCH_CYCLES = 1500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        a_req,
   input  logic        b_req,
   output logic        a_gnt,
   output logic        b_gnt,
   input  logic [23:0] a_rgb,
   input  logic [23:0] b_rgb,
   output logic [7:0]  led_addr,
   output logic        pix_valid,
   output logic [23:0] pix_rgb,
   input  logic        pix_ready,
   output logic        latch,
   output logic        busy,
   output logic        frame_done
);

   localparam int         CW       = (LATCH_CYCLES > 2) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [7:0] LAST_PIX = 8'(NUM_LEDS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_LATCH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          prev_a;   // previous frame went to A; steers the next tie to B
   logic          pend;
   logic          start;
   logic          pick_b;
   logic          cnt_end;

   assign start   = (frame_start | pend) & (a_req | b_req);
   assign pick_b  = b_req & (~a_req | prev_a);
   assign cnt_end = (cnt == LAST_CNT);

`ifdef WS_SCHED_PENDING_EN
   // one-deep memory of a start request seen while busy; consumed on the first IDLE cycle
   always_ff @(posedge clk) begin
      if (reset)                pend <= 1'b0;
      else if (state == S_IDLE) pend <= 1'b0;
      else if (frame_start)     pend <= 1'b1;
   end
`else
   assign pend = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_SEND;
         S_SEND:  if (pix_ready) state_nxt = (led_addr == LAST_PIX) ? S_LATCH : S_FETCH;
         S_LATCH: if (cnt_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != S_IDLE);
      latch      = (state == S_LATCH);
      frame_done = (state == S_LATCH) && cnt_end;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         prev_a    <= 1'b0;
         led_addr  <= 8'd0;
         pix_valid <= 1'b0;
         pix_rgb   <= 24'd0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               a_gnt    <= ~pick_b;
               b_gnt    <= pick_b;
               prev_a   <= ~pick_b;
               led_addr <= 8'd0;
            end
            S_FETCH: begin
               pix_rgb   <= b_gnt ? b_rgb : a_rgb;
               pix_valid <= 1'b1;
            end
            S_SEND: if (pix_ready) begin
               pix_valid <= 1'b0;
               if (led_addr == LAST_PIX) begin
                  led_addr <= 8'd0;
                  cnt      <= '0;
               end else begin
                  led_addr <= led_addr + 8'd1;
               end
            end
            S_LATCH: begin
               if (cnt_end) begin
                  cnt   <= '0;
                  a_gnt <= 1'b0;
                  b_gnt <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ws_frame_scheduler.md
WS_FRAME_SCHEDULER -- requirements
Module: ws_frame_scheduler

Interface
REQ-001 Parameter NUM_LEDS, default 50, LEDs per frame (legal 1..255).
REQ-002 Parameter LATCH_CYCLES, default 1500, clock cycles of line-low latch gap after the last pixel (legal >= 2).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle request to send one frame.
REQ-006 a_req, b_req  input  1 each  source A / source B wants the strip.
REQ-007 a_gnt, b_gnt  output  1 each  source owns the current frame.
REQ-008 a_rgb, b_rgb  input  24 each  {red,green,blue} for the pixel at led_addr, valid the cycle after led_addr changes.
REQ-009 led_addr  output  8  pixel index presented to the granted source.
REQ-010 pix_valid  output  1  pix_rgb holds a pixel for the serializer.
REQ-011 pix_rgb  output  24  pixel data {red,green,blue}.
REQ-012 pix_ready  input  1  serializer accepts pix_rgb this cycle.
REQ-013 latch  output  1  high during the latch gap.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-016 States SHALL be IDLE, FETCH, SEND, LATCH.
REQ-017 IDLE: frame_start=1 with a_req or b_req high SHALL register a grant and move to FETCH with led_addr=0; frame_start with no request SHALL be ignored.
REQ-018 Only one request: grant that source. Both requesting: grant the source not granted in the previous frame; the first tie after reset goes to A.
REQ-019 The grant SHALL hold from IDLE exit until the frame_done cycle inclusive; request deassertion mid-frame SHALL NOT drop it.
REQ-020 FETCH: one cycle; at its end pix_rgb SHALL load the granted source's rgb, pix_valid SHALL rise, and the state SHALL become SEND.
REQ-021 SEND: pix_valid and pix_rgb SHALL stay stable until pix_valid&&pix_ready; pix_ready while pix_valid=0 has no effect.
REQ-022 On transfer with led_addr<NUM_LEDS-1: led_addr increments, pix_valid falls, next state FETCH (no back-to-back transfers; minimum 2 cycles per pixel).
REQ-023 On transfer with led_addr=NUM_LEDS-1: pix_valid falls, led_addr returns to 0, latch rises, next state LATCH.
REQ-024 LATCH: latch SHALL stay high exactly LATCH_CYCLES cycles; in the final cycle frame_done=1 and the next state is IDLE with grants cleared.
REQ-025 frame_start while busy SHALL be handled per REQ-030/031.
REQ-026 NUM_LEDS=1: exactly one pixel transfer, then LATCH.

Reset
REQ-027 On reset=1 at an edge, regardless of state: state IDLE, led_addr=0, pix_rgb=0, pix_valid=0, latch=0, busy=0, frame_done=0, a_gnt=b_gnt=0, latch counter 0, tie flag favours A, pending flag 0.
REQ-028 Reset mid-frame SHALL abort without frame_done; the next frame starts only on a new frame_start.
REQ-029 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-030 With WS_SCHED_PENDING_EN defined: frame_start while busy SHALL set a one-deep pending flag (extras lost); on the IDLE cycle after frame_done the pending flag SHALL act as frame_start, arbitrating on that cycle's requests, and clear.
REQ-031 Without WS_SCHED_PENDING_EN: frame_start while busy SHALL be ignored and no pending state exists.

Verification
REQ-032 NUM_LEDS=3, LATCH_CYCLES=4, a_req=1, a_rgb=addr-dependent, pix_ready=1 -> transfers of addr 0,1,2 in order, latch high 4 cycles, frame_done one pulse, a_gnt=0 after.
REQ-033 Both requests held, three frame_starts -> grants A, B, A.
REQ-034 pix_ready low 5 cycles while pix_valid=1 -> pix_rgb and led_addr unchanged throughout; one transfer only.
REQ-035 reset=1 during SEND at addr 1 -> next cycle all outputs at reset values; no frame_done.
REQ-036 frame_start during LATCH -> with WS_SCHED_PENDING_EN a new frame starts the cycle after frame_done; without it, state stays IDLE.
